// File: rtl/mac_out_writer.sv
// Drain stage of the MAC array: packs the result stream four lanes per 64-bit word into output memory.
// Optional macro ACCUM_EN turns each word write into a read-modify-write that accumulates into memory.
module mac_out_writer #(
  parameter int RES_W  = 16,
  parameter int LANES  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic [11:0]              MNT,
  input  logic                     START,
  input  logic                     RES_VALID,
  output logic                     RES_READY,
  input  logic [RES_W-1:0]         RES_DATA,
  output logic                     EN_O,
  output logic                     RW_O,
  output logic [ADDR_W-1:0]        ADDR_O,
  output logic [RES_W*LANES-1:0]   WDATA_O,
  input  logic [RES_W*LANES-1:0]   RDATA_O,
  output logic                     BUSY,
  output logic                     DONE
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_FIN     = 3'd3;
`ifdef ACCUM_EN
  localparam logic [2:0] S_RD      = 3'd4;
  localparam logic [2:0] S_RDWAIT  = 3'd5;
`endif

  logic [2:0]       state;
  logic [3:0]       m_reg;
  logic [3:0]       t_reg;
  logic [2:0]       row;
  logic [2:0]       col;
  logic [RES_W-1:0] lanes [LANES];
  logic [LANES-1:0] filled;

  logic [RES_W-1:0] lanes_nx [LANES];
  logic [LANES-1:0] filled_nx;
  logic             xfer;
  logic             last_col;
  logic             last_row;
  logic             word_end;

  // Dimensions beyond the 8x8 output tile are clamped so addressing never wraps.
  function automatic logic [3:0] clamp8(input logic [3:0] v);
    return (v > 4'd8) ? 4'd8 : v;
  endfunction

  assign xfer     = RES_VALID & RES_READY;
  assign last_col = ({1'b0, col} == (t_reg - 4'd1));
  assign last_row = ({1'b0, row} == (m_reg - 4'd1));
  assign word_end = (col[1:0] == 2'd3) | last_col;

  always_comb begin
    for (int k = 0; k < LANES; k++) lanes_nx[k] = lanes[k];
    filled_nx = filled;
    if (xfer) begin
      lanes_nx[col[1:0]]  = RES_DATA;
      filled_nx[col[1:0]] = 1'b1;
    end
  end

`ifdef ACCUM_EN
  logic [RES_W*LANES-1:0] merge_word;
  logic                   unused_ok;

  // Filled lanes add onto the stored partial sum; unfilled lanes write back the old value.
  always_comb begin
    merge_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (filled[k])
        merge_word[k*RES_W +: RES_W] = RDATA_O[k*RES_W +: RES_W] + lanes[k];
      else
        merge_word[k*RES_W +: RES_W] = RDATA_O[k*RES_W +: RES_W];
    end
  end

  assign unused_ok = ^MNT[7:4];
`else
  logic [RES_W*LANES-1:0] new_word;
  logic                   unused_ok;

  always_comb begin
    new_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (filled_nx[k]) new_word[k*RES_W +: RES_W] = lanes_nx[k];
    end
  end

  assign unused_ok = ^{RDATA_O, MNT[7:4]};
`endif

  // Every output is registered, so memory strobes are set on the edge that enters their state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      m_reg     <= '0;
      t_reg     <= '0;
      row       <= '0;
      col       <= '0;
      filled    <= '0;
      for (int k = 0; k < LANES; k++) lanes[k] <= '0;
      RES_READY <= 1'b0;
      EN_O      <= 1'b0;
      RW_O      <= 1'b0;
      ADDR_O    <= '0;
      WDATA_O   <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            m_reg  <= clamp8(MNT[11:8]);
            t_reg  <= clamp8(MNT[3:0]);
            row    <= '0;
            col    <= '0;
            filled <= '0;
            for (int k = 0; k < LANES; k++) lanes[k] <= '0;
            if ((MNT[11:8] == 4'd0) || (MNT[3:0] == 4'd0)) begin
              DONE  <= 1'b1;
              state <= S_FIN;
            end else begin
              BUSY      <= 1'b1;
              RES_READY <= 1'b1;
              state     <= S_COLLECT;
            end
          end
        end

        S_COLLECT: begin
          if (xfer) begin
            for (int k = 0; k < LANES; k++) lanes[k] <= lanes_nx[k];
            filled <= filled_nx;
            if (word_end) begin
              RES_READY <= 1'b0;
              EN_O      <= 1'b1;
              ADDR_O    <= {row, col[2]};
`ifdef ACCUM_EN
              RW_O      <= 1'b0;
              state     <= S_RD;
`else
              RW_O      <= 1'b1;
              WDATA_O   <= new_word;
              state     <= S_WRITE;
`endif
            end else begin
              col <= col + 3'd1;
            end
          end
        end

`ifdef ACCUM_EN
        S_RD: begin
          EN_O  <= 1'b0;
          state <= S_RDWAIT;
        end

        S_RDWAIT: begin
          EN_O    <= 1'b1;
          RW_O    <= 1'b1;
          WDATA_O <= merge_word;
          state   <= S_WRITE;
        end
`endif

        S_WRITE: begin
          EN_O   <= 1'b0;
          RW_O   <= 1'b0;
          filled <= '0;
          for (int k = 0; k < LANES; k++) lanes[k] <= '0;
          if (last_col && last_row) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= S_FIN;
          end else begin
            RES_READY <= 1'b1;
            state     <= S_COLLECT;
            if (last_col) begin
              col <= '0;
              row <= row + 3'd1;
            end else begin
              col <= col + 3'd1;
            end
          end
        end

        S_FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_out_writer.sv
// Self-checking bench for mac_out_writer: table vectors, random jobs against a packing model, abort and accumulate cases.
module tb_mac_out_writer;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [11:0] MNT = '0;
  logic        START = 1'b0;
  logic        RES_VALID = 1'b0;
  logic        RES_READY;
  logic [15:0] RES_DATA = '0;
  logic        EN_O;
  logic        RW_O;
  logic [3:0]  ADDR_O;
  logic [63:0] WDATA_O;
  logic [63:0] RDATA_O = '0;
  logic        BUSY;
  logic        DONE;

  mac_out_writer dut (
    .CLK(CLK), .RSTN(RSTN), .MNT(MNT), .START(START),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .WDATA_O(WDATA_O), .RDATA_O(RDATA_O),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [63:0] mem [16];
  logic [63:0] preMem [16];
  logic [3:0]  logAddr [$];
  logic [63:0] logData [$];
  int          logCyc [$];
  int          readCount, enCycles, doneCount, doneCyc, readCycFirst;
  logic [3:0]  readAddrFirst;
  logic [15:0] elems [$];

  typedef struct {
    int          m;
    int          t;
    logic [15:0] base;
    bit          gap;
    bit          busyStart;
    int          expWrites;
    logic [3:0]  firstAddr;
    logic [63:0] firstData;
    logic [3:0]  lastAddr;
    logic [63:0] lastData;
  } vec_t;

  vec_t vecs [6];

  // Memory model sampled mid-cycle: writes land, reads return data for the following cycle.
  always @(negedge CLK) begin
    if (EN_O) begin
      enCycles++;
      if (RW_O) begin
        mem[ADDR_O] = WDATA_O;
        logAddr.push_back(ADDR_O);
        logData.push_back(WDATA_O);
        logCyc.push_back(cyc);
      end else begin
        if (readCount == 0) begin
          readAddrFirst = ADDR_O;
          readCycFirst  = cyc;
        end
        readCount++;
        RDATA_O = mem[ADDR_O];
      end
    end
    if (DONE) begin
      doneCount++;
      doneCyc = cyc;
    end
  end

  function automatic int clamp8(input int v);
    return (v > 8) ? 8 : v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clearLogs();
    logAddr.delete();
    logData.delete();
    logCyc.delete();
    readCount = 0;
    enCycles  = 0;
    doneCount = 0;
    doneCyc   = -1;
    readCycFirst  = -1;
    readAddrFirst = '0;
  endtask

  task automatic fillElems(input int n, input logic [15:0] base, input bit randData);
    elems.delete();
    for (int i = 0; i < n; i++) begin
      if (randData) elems.push_back(16'($urandom_range(0, 65535)));
      else          elems.push_back(base + 16'(i));
    end
  endtask

  task automatic applyStimulus(input int mIn, input int tIn, input bit gap, input bit busyStart,
                               input bit keepMem, input int abortAt,
                               output int consumed, output int startCyc);
    int  budget;
    bit  acc;
    bit  pulsed;
    if (!keepMem) for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) preMem[i] = mem[i];
    clearLogs();
    @(posedge CLK); #1;
    START = 1'b1;
    MNT   = {mIn[3:0], 4'($urandom_range(0, 15)), tIn[3:0]};
    @(negedge CLK);
    startCyc = cyc;
    @(posedge CLK); #1;
    START    = 1'b0;
    consumed = 0;
    pulsed   = 1'b0;
    budget   = 3000;
    while (doneCount == 0 && budget > 0 && consumed != abortAt) begin
      START = 1'b0;
      if (!RES_VALID && consumed < elems.size()) begin
        if (!gap || $urandom_range(0, 2) != 0) begin
          RES_VALID = 1'b1;
          RES_DATA  = elems[consumed];
        end
      end
      if (busyStart && !pulsed && consumed == 3) begin
        START  = 1'b1;
        MNT    = 12'h000;
        pulsed = 1'b1;
      end
      @(negedge CLK);
      acc = RES_VALID && RES_READY;
      @(posedge CLK); #1;
      if (acc) begin
        consumed++;
        RES_VALID = 1'b0;
      end
      budget--;
    end
    START     = 1'b0;
    RES_VALID = 1'b0;
    if (consumed != abortAt) begin
      if (doneCount == 0) checkOutput("done_timeout", 64'd0, 64'd1);
      repeat (4) @(posedge CLK);
      #1;
    end
  endtask

  // Expected writes come straight from row-major packing: word w of row r holds columns 4w..4w+3.
  task automatic verifyJob(input string name, input int mIn, input int tIn, input int consumed, input int startCyc);
    int          mE, tE, nexp, words;
    logic [3:0]  expA;
    logic [63:0] expD;
    logic [15:0] lane, old;
    mE = clamp8(mIn);
    tE = clamp8(tIn);
    words = (tE + 3) / 4;
    nexp = 0;
    if (mE > 0 && tE > 0) begin
      for (int r = 0; r < mE; r++) begin
        for (int w = 0; w < words; w++) begin
          expA = 4'(r * 2 + w);
          expD = '0;
          for (int k = 0; k < 4; k++) begin
`ifdef ACCUM_EN
            old = preMem[expA][k*16 +: 16];
`else
            old = 16'd0;
`endif
            if (4 * w + k < tE) lane = elems[r * tE + 4 * w + k] + old;
            else                lane = old;
            expD[k*16 +: 16] = lane;
          end
          if (nexp < logAddr.size()) begin
            checkOutput({name, "_addr"}, 64'(logAddr[nexp]), 64'(expA));
            checkOutput({name, "_data"}, logData[nexp], expD);
          end
          nexp++;
        end
      end
    end
    checkOutput({name, "_write_count"}, 64'(logAddr.size()), 64'(nexp));
    checkOutput({name, "_consumed"}, 64'(consumed), 64'(mE * tE));
    checkOutput({name, "_done_pulses"}, 64'(doneCount), 64'd1);
`ifdef ACCUM_EN
    checkOutput({name, "_reads"}, 64'(readCount), 64'(nexp));
`else
    checkOutput({name, "_reads"}, 64'(readCount), 64'd0);
`endif
    checkOutput({name, "_en_cycles"}, 64'(enCycles), 64'(logAddr.size() + readCount));
    if (logCyc.size() > 0)
      checkOutput({name, "_done_after_write"}, 64'(doneCyc), 64'(logCyc[$] + 1));
    else
      checkOutput({name, "_done_delay_ok"}, 64'((doneCyc - startCyc >= 1) && (doneCyc - startCyc <= 2)), 64'd1);
    checkOutput({name, "_busy_idle"}, 64'(BUSY), 64'd0);
  endtask

  initial begin
    int consumed, startCyc, n;

    vecs[0] = '{2, 4, 16'h0001, 1'b0, 1'b0, 2, 4'd0, 64'h0004_0003_0002_0001, 4'd2, 64'h0008_0007_0006_0005};
    vecs[1] = '{1, 6, 16'h0010, 1'b0, 1'b0, 2, 4'd0, 64'h0013_0012_0011_0010, 4'd1, 64'h0000_0000_0015_0014};
    vecs[2] = '{3, 1, 16'h0100, 1'b1, 1'b0, 3, 4'd0, 64'h0000_0000_0000_0100, 4'd4, 64'h0000_0000_0000_0102};
    vecs[3] = '{1, 8, 16'h000A, 1'b0, 1'b1, 2, 4'd0, 64'h000D_000C_000B_000A, 4'd1, 64'h0011_0010_000F_000E};
    vecs[4] = '{12, 15, 16'h0000, 1'b1, 1'b0, 16, 4'd0, 64'h0003_0002_0001_0000, 4'd15, 64'h003F_003E_003D_003C};
    vecs[5] = '{2, 3, 16'hFFF0, 1'b1, 1'b0, 2, 4'd0, 64'h0000_FFF2_FFF1_FFF0, 4'd2, 64'h0000_FFF5_FFF4_FFF3};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    clearLogs();
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_outputs", {RES_READY, EN_O, RW_O, ADDR_O, WDATA_O, BUSY, DONE}, 64'd0);
    @(negedge CLK);
    RSTN = 1'b1;

    for (int v = 0; v < 6; v++) begin
      n = clamp8(vecs[v].m) * clamp8(vecs[v].t);
      fillElems(n, vecs[v].base, 1'b0);
      applyStimulus(vecs[v].m, vecs[v].t, vecs[v].gap, vecs[v].busyStart, 1'b0, -1, consumed, startCyc);
      verifyJob($sformatf("vec%0d", v), vecs[v].m, vecs[v].t, consumed, startCyc);
      checkOutput($sformatf("vec%0d_exp_writes", v), 64'(logAddr.size()), 64'(vecs[v].expWrites));
      if (logAddr.size() > 0) begin
        checkOutput($sformatf("vec%0d_first", v), {logAddr[0], logData[0]}, {vecs[v].firstAddr, vecs[v].firstData});
        checkOutput($sformatf("vec%0d_last", v), {logAddr[$], logData[$]}, {vecs[v].lastAddr, vecs[v].lastData});
      end
    end

    fillElems(0, 16'h0, 1'b0);
    applyStimulus(0, 5, 1'b0, 1'b0, 1'b0, -1, consumed, startCyc);
    verifyJob("zero_m", 0, 5, consumed, startCyc);

    for (int j = 0; j < 8; j++) begin
      int rm, rt;
      rm = $urandom_range(1, 8);
      rt = $urandom_range(1, 8);
      fillElems(rm * rt, 16'h0, 1'b1);
      applyStimulus(rm, rt, 1'($urandom_range(0, 1)), 1'b0, 1'b0, -1, consumed, startCyc);
      verifyJob($sformatf("rand%0d_m%0d_t%0d", j, rm, rt), rm, rt, consumed, startCyc);
    end

    // Abort after three elements: reset must clear outputs at once and suppress the pending write.
    fillElems(8, 16'h0001, 1'b0);
    applyStimulus(2, 4, 1'b0, 1'b0, 1'b0, 3, consumed, startCyc);
    checkOutput("abort_consumed", 64'(consumed), 64'd3);
    #2;
    RSTN = 1'b0;
    #1;
    checkOutput("abort_outputs", {RES_READY, EN_O, RW_O, ADDR_O, WDATA_O, BUSY, DONE}, 64'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("abort_no_write", 64'(logAddr.size() + enCycles + doneCount), 64'd0);
    checkOutput("abort_idle", {RES_READY, BUSY}, 64'd0);
    fillElems(8, 16'h0001, 1'b0);
    applyStimulus(2, 4, 1'b0, 1'b0, 1'b0, -1, consumed, startCyc);
    verifyJob("after_abort", 2, 4, consumed, startCyc);

`ifdef ACCUM_EN
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 64'h0001_0001_0001_0001;
    elems.delete();
    elems.push_back(16'h0002);
    elems.push_back(16'h0003);
    elems.push_back(16'hFFFF);
    applyStimulus(1, 3, 1'b0, 1'b0, 1'b1, -1, consumed, startCyc);
    verifyJob("accum", 1, 3, consumed, startCyc);
    checkOutput("accum_read_addr", 64'(readAddrFirst), 64'd0);
    if (logData.size() > 0) begin
      checkOutput("accum_read_first", 64'(readCycFirst < logCyc[0]), 64'd1);
      checkOutput("accum_word", logData[0], 64'h0001_0000_0004_0003);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
